router_sync: RTL and testbench
==============================

ROUTER_SYNC -- requirements
Module: router_sync

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-003 Port `resetn`: input, 1 bit, synchronous reset, active-high (1 = reset); the name is kept as-is despite the polarity.
REQ-004 Port `detect_add`: input, 1 bit, header-detected strobe; loads the destination address.
REQ-005 Port `datain`: input, 2 bits, destination address field (00/01/10 = FIFO 0/1/2; 11 = invalid).
REQ-006 Port `write_enb_reg`: input, 1 bit, write request from the FSM.
REQ-007 Ports `full_0`, `full_1`, `full_2`: input, 1 bit each, FIFO full flags.
REQ-008 Ports `empty_0`, `empty_1`, `empty_2`: input, 1 bit each, FIFO empty flags.
REQ-009 Ports `read_enb_0`, `read_enb_1`, `read_enb_2`: input, 1 bit each, consumer read enables.
REQ-010 Port `write_enb`: output, 3 bits, one-hot FIFO write enable.
REQ-011 Port `fifo_full`: output, 1 bit, full flag of the addressed FIFO.
REQ-012 Ports `vld_out_0`, `vld_out_1`, `vld_out_2`: output, 1 bit each, FIFO data-valid.
REQ-013 Ports `soft_reset_0`, `soft_reset_1`, `soft_reset_2`: output, 1 bit each, FIFO timeout soft reset.
REQ-014 Parameter `TIMEOUT`: default 30, number of consecutive un-read valid cycles that triggers a soft reset.

Function
REQ-015 An internal 2-bit address register SHALL load `datain` on the rising edge when `detect_add`=1, and SHALL hold its value otherwise.
REQ-016 `write_enb` SHALL be combinational from the address register (one-cycle latency from `detect_add`):
- `write_enb_reg`=0: 000.
- Address 00: 001.
- Address 01: 010.
- Address 10: 100.
- Address 11: 000.
REQ-017 `fifo_full` SHALL be combinational: `full_0`/`full_1`/`full_2` for address 00/01/10, and 0 for address 11.
REQ-018 `vld_out_x` SHALL equal the inverse of `empty_x` combinationally, for x = 0..2, independent of reset.
REQ-019 Each channel x SHALL have an independent 5-bit timeout counter.
REQ-020 Each rising edge with `vld_out_x`=1 and `read_enb_x`=0:
- If the counter = TIMEOUT-1, `soft_reset_x` SHALL be 1 and the counter SHALL return to 0.
- Otherwise the counter SHALL increment and `soft_reset_x` SHALL be 0.
REQ-021 Each rising edge with `vld_out_x`=0 or `read_enb_x`=1: the counter SHALL clear to 0 and `soft_reset_x` SHALL be 0.
REQ-022 `soft_reset_x` SHALL be registered and SHALL last exactly one cycle, asserting after the TIMEOUT-th consecutive qualifying edge.
REQ-023 If the stall condition persists, `soft_reset_x` SHALL repeat every TIMEOUT cycles.
REQ-024 A read during a count SHALL restart the full TIMEOUT window.
REQ-025 The three channels SHALL be fully independent; simultaneous timeouts SHALL pulse simultaneously.
REQ-026 When `detect_add`=1 and `write_enb_reg`=1 in the same cycle, `write_enb` SHALL use the old address until the edge loads the new one.

Reset
REQ-027 With `resetn`=1 at a rising edge, the address register, all counters and all `soft_reset_x` SHALL become 0; `detect_add` SHALL be ignored in that cycle.
REQ-028 After reset, with address 00, `write_enb` SHALL be 001 if `write_enb_reg`=1, and `fifo_full` SHALL equal `full_0`.
REQ-029 Reset asserted mid-count SHALL clear the count, so a full TIMEOUT window is required after release.

Verification
REQ-030 Address decode: reset, then `detect_add`=1, `datain`=10, `write_enb_reg`=1, full=0/1/1 -> after one edge `write_enb`=100 and `fifo_full`=1; with `datain`=01, `full_1`=0 -> `write_enb`=010 and `fifo_full`=0.
REQ-031 Valid flags: empty=1/0/0 -> `vld_out_0`=0, `vld_out_1`=1, `vld_out_2`=1 in the same cycle.
REQ-032 Timeout on channel 2: `empty_2`=0, `read_enb_2`=0 held -> `soft_reset_2` pulses for one cycle after the 30th edge, then again 30 cycles later; `soft_reset_1` stays 0 while `read_enb_1`=1.
REQ-033 Timeout restart: channel 0 stalled for 20 cycles, `read_enb_0`=1 for 1 cycle, then stalled again -> `soft_reset_0` fires 30 cycles after the read, not before.
REQ-034 Invalid address: `datain`=11 loaded, `write_enb_reg`=1 -> `write_enb`=000 and `fifo_full`=0.
REQ-035 Reset mid-count: `resetn`=1 at counter 25 -> no pulse; the next pulse occurs 30 stalled cycles after release.

Source files
------------

// File: rtl/router_sync.sv
// router_sync: destination-address latch, one-hot FIFO write-enable decode,
// per-FIFO valid flags, and per-FIFO stall timeout that issues a one-cycle
// soft reset when a FIFO holds data that nobody reads for TIMEOUT cycles.

// Per-channel stall timer. Counts consecutive edges where the FIFO has data
// but is not being read; pulses soft_reset_o for one cycle on the TIMEOUT-th.
module router_sync_timer #(
    parameter int TIMEOUT = 30,
    parameter int CW      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_i,
    input  logic rd_i,
    output logic soft_reset_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sr_q, sr_d;

    // Next-state: count while stalled, wrap and pulse at the limit, clear on read/empty.
    always_comb begin
        cnt_d = '0;
        sr_d  = 1'b0;
        if (vld_i && !rd_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                sr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sr_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    assign soft_reset_o = sr_q;

endmodule

module router_sync #(
    parameter int TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       resetn,          // active-high despite the name
    input  logic       detect_add,
    input  logic [1:0] datain,
    input  logic       write_enb_reg,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam int NUM_CH = 3;

    logic [1:0]        addr_q, addr_d;
    logic [NUM_CH-1:0] vld, rd, sr;

    // Address latch: load on header detect, hold otherwise.
    always_comb begin
        addr_d = addr_q;
        if (detect_add) addr_d = datain;
    end

    // Address register; reset wins over detect_add.
    always_ff @(posedge clk) begin
        if (resetn) addr_q <= 2'b00;
        else        addr_q <= addr_d;
    end

    // Write-enable and full-flag decode from the latched (old) address.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            2'b00: begin write_enb = {2'b00, write_enb_reg};       fifo_full = full_0; end
            2'b01: begin write_enb = {1'b0, write_enb_reg, 1'b0};  fifo_full = full_1; end
            2'b10: begin write_enb = {write_enb_reg, 2'b00};       fifo_full = full_2; end
            default: begin write_enb = 3'b000;                     fifo_full = 1'b0;   end
        endcase
    end

    // Valid is purely the inverse of empty, unaffected by reset.
    assign vld = ~{empty_2, empty_1, empty_0};
    assign rd  = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        router_sync_timer #(
            .TIMEOUT (TIMEOUT),
            .CW      (5)
        ) u_timer (
            .clk          (clk),
            .rst          (resetn),
            .vld_i        (vld[g]),
            .rd_i         (rd[g]),
            .soft_reset_o (sr[g])
        );
    end

    assign soft_reset_0 = sr[0];
    assign soft_reset_1 = sr[1];
    assign soft_reset_2 = sr[2];

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: table of decode/valid vectors plus
// hand-written timeout sequences.
module tb_router_sync;

    logic       clk = 1'b0;
    logic       resetn;
    logic       detect_add;
    logic [1:0] datain;
    logic       write_enb_reg;
    logic       full_0, full_1, full_2;
    logic       empty_0, empty_1, empty_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int checks = 0;
    int errors = 0;

    router_sync #(.TIMEOUT(30)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .datain        (datain),
        .write_enb_reg (write_enb_reg),
        .full_0        (full_0),
        .full_1        (full_1),
        .full_2        (full_2),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .empty_2       (empty_2),
        .read_enb_0    (read_enb_0),
        .read_enb_1    (read_enb_1),
        .read_enb_2    (read_enb_2),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2)
    );

    always #5 clk = ~clk;

    // full/empty vectors are {x2, x1, x0}
    typedef struct {
        logic       det;
        logic [1:0] din;
        logic       wer;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_vld;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic set_fe(input logic [2:0] f, input logic [2:0] e);
        {full_2, full_1, full_0}    = f;
        {empty_2, empty_1, empty_0} = e;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
    endtask

    task automatic chk_sr(input string name, input int idx, input logic [2:0] exp);
        chk(name, idx, {29'd0, soft_reset_2, soft_reset_1, soft_reset_0}, {29'd0, exp});
    endtask

    initial begin
        //           det  din    wer  full    empty   we      ff    vld
        vecs[0] = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000};
        vecs[1] = '{1'b1, 2'b10, 1'b1, 3'b110, 3'b001, 3'b100, 1'b1, 3'b110};
        vecs[2] = '{1'b1, 2'b01, 1'b1, 3'b100, 3'b000, 3'b010, 1'b0, 3'b111};
        vecs[3] = '{1'b0, 2'b11, 1'b0, 3'b010, 3'b100, 3'b000, 1'b1, 3'b011};
        vecs[4] = '{1'b1, 2'b11, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[5] = '{1'b1, 2'b00, 1'b1, 3'b000, 3'b010, 3'b001, 1'b0, 3'b101};
        vecs[6] = '{1'b0, 2'b10, 1'b1, 3'b001, 3'b110, 3'b001, 1'b1, 3'b001};
        vecs[7] = '{1'b1, 2'b10, 1'b0, 3'b111, 3'b101, 3'b000, 1'b1, 3'b010};

        resetn = 1'b1; detect_add = 1'b1; datain = 2'b10; write_enb_reg = 1'b1;
        set_fe(3'b100, 3'b111);
        {read_enb_2, read_enb_1, read_enb_0} = 3'b111;

        // Reset: detect_add ignored, address 00
        tick(); tick();
        resetn = 1'b0; detect_add = 1'b0;
        chk("rst_we", 0, {29'd0, write_enb}, 32'b001);
        chk("rst_ff", 0, {31'd0, fifo_full}, 32'd0);
        chk_sr("rst_sr", 0, 3'b000);
        full_0 = 1'b1; #1;
        chk("rst_ff_follow", 0, {31'd0, fifo_full}, 32'd1);

        // Table: apply inputs, clock once, check decode/valid
        for (int i = 0; i < 8; i++) begin
            detect_add = vecs[i].det; datain = vecs[i].din; write_enb_reg = vecs[i].wer;
            set_fe(vecs[i].full, vecs[i].empty);
            tick();
            chk("we", i, {29'd0, write_enb}, {29'd0, vecs[i].exp_we});
            chk("ff", i, {31'd0, fifo_full}, {31'd0, vecs[i].exp_ff});
            chk("vld", i, {29'd0, vld_out_2, vld_out_1, vld_out_0}, {29'd0, vecs[i].exp_vld});
        end

        // Valid is combinational and independent of reset
        resetn = 1'b1; set_fe(3'b000, 3'b001); #1;
        chk("vld_in_rst", 0, {29'd0, vld_out_2, vld_out_1, vld_out_0}, 32'b110);
        tick(); resetn = 1'b0;

        // Same-cycle detect uses old address until the edge
        detect_add = 1'b1; datain = 2'b00; write_enb_reg = 1'b1; tick();
        datain = 2'b10; #1;
        chk("old_addr_we", 0, {29'd0, write_enb}, 32'b001);
        tick(); detect_add = 1'b0;
        chk("new_addr_we", 0, {29'd0, write_enb}, 32'b100);

        // Channel 2 stalled, channel 1 valid but read, channel 0 empty
        do_reset();
        set_fe(3'b000, 3'b001);
        {read_enb_2, read_enb_1, read_enb_0} = 3'b010;
        for (int i = 1; i <= 65; i++) begin
            tick();
            chk_sr("ch2_to", i, (i % 30 == 0) ? 3'b100 : 3'b000);
        end

        // Channel 0: stall 20, read 1, stall -> pulse 30 edges after the read
        do_reset();
        set_fe(3'b000, 3'b110);
        {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk_sr("ch0_pre", i, 3'b000);
        end
        read_enb_0 = 1'b1; tick(); read_enb_0 = 1'b0;
        chk_sr("ch0_read", 0, 3'b000);
        for (int i = 1; i <= 35; i++) begin
            tick();
            chk_sr("ch0_restart", i, (i == 30) ? 3'b001 : 3'b000);
        end

        // All channels stalled: simultaneous pulses
        do_reset();
        set_fe(3'b000, 3'b000);
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk_sr("all_to", i, (i == 30) ? 3'b111 : 3'b000);
        end

        // Reset mid-count at 25: no pulse, full window after release
        do_reset();
        for (int i = 1; i <= 25; i++) tick();
        resetn = 1'b1; tick(); resetn = 1'b0;
        chk_sr("mid_rst", 0, 3'b000);
        for (int i = 1; i <= 35; i++) begin
            tick();
            chk_sr("after_rst", i, (i == 30) ? 3'b111 : 3'b000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
